traffic_seq: RTL and testbench

TRAFFIC_SEQ -- requirements
Module: traffic_seq

---
 rtl/traffic_seq_if.sv | 21 ++
 rtl/traffic_seq.sv | 65 ++++++
 tb/tb_traffic_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/traffic_seq_if.sv
// traffic_seq_if: signal bundle between the light sequencer and its countdown stage
interface traffic_seq_if;
    logic       tick;
    logic [4:0] next_time;
    logic       stop;
    logic       save;
    logic       red;
    logic       yellow;
    logic       green;
    logic [4:0] rest_time;
    logic       load;
    logic       dis;
    modport master (
        output tick, next_time, stop, save,
        input  red, yellow, green, rest_time, load, dis
    );
    modport slave (
        input  tick, next_time, stop, save,
        output red, yellow, green, rest_time, load, dis
    );
endinterface

// File: rtl/traffic_seq.sv
// traffic_seq: red/green/yellow phase sequencer with freeze, night flash and countdown reload
module traffic_seq #(
    parameter int RED_T    = 15,
    parameter int GREEN_T  = 20,
    parameter int YELLOW_T = 5
) (
    input logic          clk,
    input logic          rst,
    traffic_seq_if.slave bus_if
);
    typedef enum logic [2:0] {S_INIT, S_RED, S_GREEN, S_YELLOW, S_SAVE} state_t;
    state_t     state_q, state_d;
    logic [4:0] rest_q;
    logic [4:0] load_val;
    logic [1:0] blank_q;
    logic       load_q, flash_q;
    logic       enter, expire;
    // a timed phase is entered on any edge that moves into RED, GREEN or YELLOW
    assign enter    = state_d != state_q && (state_d == S_RED || state_d == S_GREEN || state_d == S_YELLOW);
    // the timer's zero only counts once the blanking window after a load has passed
    assign expire   = !bus_if.stop && blank_q == 2'd0 && bus_if.next_time == 5'd0;
    assign load_val = state_d == S_RED ? 5'(RED_T) : state_d == S_GREEN ? 5'(GREEN_T) : 5'(YELLOW_T);
    // state register
    always_ff @(posedge clk) begin
        state_q <= rst ? S_INIT : state_d;
    end
    // next state: save overrides all, INIT and SAVE exit to RED, timed phases advance on expiry
    always_comb begin
        state_d = state_q;
        if (bus_if.save) begin
            state_d = S_SAVE;
        end else begin
            case (state_q)
                S_INIT, S_SAVE: state_d = S_RED;
                S_RED:          state_d = expire ? S_GREEN : S_RED;
                S_GREEN:        state_d = expire ? S_YELLOW : S_GREEN;
                S_YELLOW:       state_d = expire ? S_RED : S_YELLOW;
                default:        state_d = S_INIT;
            endcase
        end
    end
    // reload value, load pulse, two-cycle blanking window and night flash bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rest_q  <= 5'd0;
            load_q  <= 1'b0;
            blank_q <= 2'd0;
            flash_q <= 1'b0;
        end else begin
            load_q  <= enter;
            blank_q <= enter ? 2'd2 : (blank_q != 2'd0 ? blank_q - 2'd1 : 2'd0);
            rest_q  <= state_d == S_SAVE ? 5'd0 : (enter ? load_val : rest_q);
            flash_q <= state_q == S_SAVE && state_d == S_SAVE && (flash_q ^ bus_if.tick);
        end
    end
    // lamp, reload and display drives from the current phase
    always_comb begin
        bus_if.red       = state_q == S_INIT || state_q == S_RED;
        bus_if.green     = state_q == S_INIT || state_q == S_GREEN;
        bus_if.yellow    = state_q == S_INIT || state_q == S_YELLOW || (state_q == S_SAVE && flash_q);
        bus_if.dis       = state_q == S_INIT || state_q == S_SAVE;
        bus_if.rest_time = rest_q;
        bus_if.load      = load_q;
    end
endmodule

// File: tb/tb_traffic_seq.sv
// tb_traffic_seq: vector table, scenario sequences and randomized run against a phase-level model
module tb_traffic_seq;
    typedef enum int {P_INIT, P_RED, P_GREEN, P_YELLOW, P_SAVE} ph_t;
    typedef struct {
        bit         r, sv, st, tk;
        logic [4:0] nt;
        logic [9:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    traffic_seq_if bus();
    traffic_seq dut (.clk(clk), .rst(rst), .bus_if(bus));

    logic [9:0] dut_out;
    assign dut_out = {bus.red, bus.yellow, bus.green, bus.rest_time, bus.load, bus.dis};

    int  n_pass = 0, n_tot = 0;
    ph_t m_ph = P_INIT;
    int  m_age = 0, m_rest = 0, cd = 0;
    bit  m_flash = 0, m_load = 0, use_cd = 0;
    vec_t tbl[23];

    task automatic chk(input string nm, input logic [9:0] got, input logic [9:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    endtask

    function automatic int dur(ph_t p);
        return p == P_RED ? 15 : p == P_GREEN ? 20 : 5;
    endfunction

    function automatic logic [9:0] m_out();
        bit i;
        i = m_ph == P_INIT;
        return {i || m_ph == P_RED, i || m_ph == P_YELLOW || (m_ph == P_SAVE && m_flash),
                i || m_ph == P_GREEN, 5'(m_rest), m_load, i || m_ph == P_SAVE};
    endfunction

    function automatic vec_t mk(bit r, bit sv, bit st, bit tk, int nt, logic [2:0] l, int rt, bit ld, bit ds);
        vec_t v;
        v.r = r; v.sv = sv; v.st = st; v.tk = tk; v.nt = 5'(nt);
        v.exp = {l, 5'(rt), ld, ds};
        return v;
    endfunction

    // one clock: sample inputs, advance the model and the countdown, optionally compare
    task automatic step(input bit cmp);
        bit r, sv, st, tk, pl;
        logic [4:0] nt;
        int pr;
        ph_t np;
        r = rst; sv = bus.save; st = bus.stop; tk = bus.tick; nt = bus.next_time;
        pl = m_load; pr = m_rest;
        @(posedge clk);
        #1;
        if (r) begin
            m_ph = P_INIT; m_age = 0; m_flash = 0; m_rest = 0; m_load = 0;
        end else begin
            if (sv) np = P_SAVE;
            else if (m_ph == P_INIT || m_ph == P_SAVE) np = P_RED;
            else if (!st && m_age >= 2 && nt == 0) np = m_ph == P_YELLOW ? P_RED : ph_t'(m_ph + 1);
            else np = m_ph;
            if (np != m_ph) begin
                m_age = 0; m_flash = 0;
                m_load = np != P_SAVE;
                m_rest = np == P_SAVE ? 0 : dur(np);
            end else begin
                m_age++; m_load = 0;
                if (m_ph == P_SAVE && tk) m_flash = !m_flash;
            end
            m_ph = np;
        end
        if (use_cd) begin
            cd = pl ? pr : (tk && cd > 0) ? cd - 1 : cd;
            bus.next_time = 5'(cd);
        end
        if (cmp) chk("model", dut_out, m_out());
    endtask

    initial begin
        int ldq[$], tq[$];
        int exp_ld[4], exp_tk[3];
        int nl, tcnt, bad, first_c;
        bit found;
        exp_ld = '{15, 20, 5, 15};
        exp_tk = '{15, 20, 5};
        bus.tick = 0; bus.next_time = 0; bus.stop = 0; bus.save = 0;

        tbl[0]  = mk(1,0,0,0,0, 3'b111, 0, 0,1);
        tbl[1]  = mk(0,0,0,0,0, 3'b100,15, 1,0);
        tbl[2]  = mk(0,0,0,0,0, 3'b100,15, 0,0);
        tbl[3]  = mk(0,0,0,0,0, 3'b100,15, 0,0);
        tbl[4]  = mk(0,0,0,0,0, 3'b001,20, 1,0);
        tbl[5]  = mk(0,0,0,0,0, 3'b001,20, 0,0);
        tbl[6]  = mk(0,0,0,0,0, 3'b001,20, 0,0);
        tbl[7]  = mk(0,0,1,0,0, 3'b001,20, 0,0);
        tbl[8]  = mk(0,0,0,0,0, 3'b010, 5, 1,0);
        tbl[9]  = mk(0,0,0,0,5, 3'b010, 5, 0,0);
        tbl[10] = mk(0,0,0,0,5, 3'b010, 5, 0,0);
        tbl[11] = mk(0,0,0,1,5, 3'b010, 5, 0,0);
        tbl[12] = mk(0,0,0,0,0, 3'b100,15, 1,0);
        tbl[13] = mk(0,1,0,0,0, 3'b000, 0, 0,1);
        tbl[14] = mk(0,1,0,1,0, 3'b010, 0, 0,1);
        tbl[15] = mk(0,1,1,0,0, 3'b010, 0, 0,1);
        tbl[16] = mk(0,1,0,1,0, 3'b000, 0, 0,1);
        tbl[17] = mk(0,0,0,0,0, 3'b100,15, 1,0);
        tbl[18] = mk(1,1,0,0,0, 3'b111, 0, 0,1);
        tbl[19] = mk(0,1,0,0,0, 3'b000, 0, 0,1);
        tbl[20] = mk(0,0,0,0,0, 3'b100,15, 1,0);
        tbl[21] = mk(1,1,0,0,0, 3'b111, 0, 0,1);
        tbl[22] = mk(0,0,0,0,0, 3'b100,15, 1,0);
        for (int i = 0; i < 23; i++) begin
            rst = tbl[i].r; bus.save = tbl[i].sv; bus.stop = tbl[i].st;
            bus.tick = tbl[i].tk; bus.next_time = tbl[i].nt;
            step(0);
            chk($sformatf("vec%0d", i), dut_out, tbl[i].exp);
        end

        // start-up and full cycle with the countdown stage, one tick every 10 cycles
        rst = 1; bus.save = 0; bus.stop = 0; bus.tick = 0;
        step(1); step(1);
        chk("init", dut_out, {3'b111, 5'd0, 1'b0, 1'b1});
        rst = 0; use_cd = 1; cd = 0; bus.next_time = 0;
        nl = 0; tcnt = 0; bad = 0; first_c = -1;
        for (int c = 0; c < 1200 && nl < 4; c++) begin
            bus.tick = (c % 10 == 9);
            if (bus.load) begin
                if (first_c < 0) first_c = c;
                ldq.push_back(int'(bus.rest_time)); tq.push_back(tcnt); tcnt = 0; nl++;
            end else tcnt += int'(bus.tick);
            if (!bus.dis && int'(bus.red) + int'(bus.yellow) + int'(bus.green) != 1) bad++;
            step(1);
        end
        chk("start latency", 10'(first_c), 10'd1);
        chk("load count", 10'(nl), 10'd4);
        chk("one lamp", 10'(bad), 10'd0);
        for (int i = 0; i < ldq.size() && i < 4; i++) chk($sformatf("load%0d", i), 10'(ldq[i]), 10'(exp_ld[i]));
        for (int i = 1; i < tq.size() && i < 4; i++) chk($sformatf("secs%0d", i), 10'(tq[i]), 10'(exp_tk[i-1]));

        // stop held in YELLOW with a zero timer
        found = 0;
        for (int c = 0; c < 1000 && !found; c++) begin
            bus.tick = (c % 10 == 9);
            step(1);
            found = m_ph == P_YELLOW;
        end
        chk("reach yellow", 10'(found), 10'd1);
        bus.tick = 0; step(1); step(1);
        use_cd = 0; bus.next_time = 0; bus.stop = 1; bad = 0;
        for (int c = 0; c < 50; c++) begin
            step(1);
            if (!bus.yellow || bus.load) bad++;
        end
        chk("stop hold", 10'(bad), 10'd0);
        bus.stop = 0; found = 0;
        for (int k = 0; k < 2 && !found; k++) begin
            step(1);
            found = bus.load;
        end
        chk("stop release", dut_out, {3'b100, 5'd15, 1'b1, 1'b0});

        // save asserted mid-GREEN, four ticks, then released
        rst = 1; step(1); rst = 0; use_cd = 1; cd = 0; found = 0;
        for (int c = 0; c < 600 && !found; c++) begin
            bus.tick = (c % 10 == 9);
            step(1);
            found = m_ph == P_GREEN;
        end
        chk("reach green", 10'(found), 10'd1);
        for (int c = 0; c < 30; c++) begin
            bus.tick = (c % 10 == 9);
            step(1);
        end
        bus.tick = 0; bus.save = 1;
        step(1);
        chk("save lamps", {bus.red, bus.yellow, bus.green, bus.dis}, 10'b0001);
        for (int k = 1; k <= 4; k++) begin
            bus.tick = 1; step(1); bus.tick = 0;
            chk($sformatf("flash%0d", k), {bus.red, bus.yellow, bus.green, bus.dis}, 10'({1'b0, k % 2 == 1, 1'b0, 1'b1}));
            step(1); step(1);
        end
        bus.save = 0;
        step(1);
        chk("save exit", dut_out, {3'b100, 5'd15, 1'b1, 1'b0});

        // randomized run against the model
        rst = 1; step(1); rst = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = $urandom_range(0, 399) == 0;
            if ($urandom_range(0, 59) == 0) bus.save = !bus.save;
            if ($urandom_range(0, 19) == 0) bus.stop = !bus.stop;
            bus.tick = $urandom_range(0, 3) == 0;
            step(1);
            if ($urandom_range(0, 5) == 0) bus.next_time = 5'($urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
